vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, h/v raster counters, and a
// one-pixel output pipeline that aligns pixel-source RGB with sync/blank.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_blank_n,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    H_SS     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    H_SE     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    V_SS     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    V_SE     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [9:0]    h_q;
  logic [9:0]    h_d;
  logic [9:0]    v_q;
  logic [9:0]    v_d;
  logic          tick_c;
  logic          tick_next_c;
  logic          active_c;
  logic          hs_raw_c;
  logic          vs_raw_c;

  assign tick_c      = (div_q == DIV_LAST);
  assign tick_next_c = (div_d == DIV_LAST);
  assign active_c    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw_c    = !((h_q >= H_SS) && (h_q < H_SE));
  assign vs_raw_c    = !((v_q >= V_SS) && (v_q < V_SE));

  assign x = h_q;
  assign y = v_q;

  // Next divider and raster position; v steps only when h wraps.
  always_comb begin
    div_d = div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick_c) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Counter state plus tick/frame pulses registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      pix_tick    <= tick_next_c;
      frame_start <= tick_next_c && (h_d == 10'd0) && (v_d == 10'd0);
    end
  end

  // Capture RGB with the sync/active of the same pixel, one pixel behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (tick_c) begin
      hsync       <= hs_raw_c;
      vsync       <= vs_raw_c;
      vga_blank_n <= active_c;
      vga_r       <= active_c ? red   : 8'd0;
      vga_g       <= active_c ? green : 8'd0;
      vga_b       <= active_c ? blue  : 8'd0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations run side by side, each with
// a driver that pushes expected observations and a monitor that pops them.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int C_HA   [NI] = '{640, 640, 8};
  localparam int C_HF   [NI] = '{16, 16, 2};
  localparam int C_HS   [NI] = '{96, 96, 3};
  localparam int C_HB   [NI] = '{48, 48, 3};
  localparam int C_VA   [NI] = '{480, 480, 4};
  localparam int C_VF   [NI] = '{10, 10, 1};
  localparam int C_VS   [NI] = '{2, 2, 2};
  localparam int C_VB   [NI] = '{33, 33, 1};
  localparam int C_DIV  [NI] = '{2, 4, 4};
  // Edge count (since reset release) at which reset is asserted mid-frame.
  localparam int C_TRIG [NI] = '{2201, 1001, 213};
  localparam int C_RUN2 [NI] = '{3400, 7000, 1200};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       tick;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fail_prints = 0;
  bit done_f [NI];

  // Expected observation from raster arithmetic: e clock edges since release.
  function automatic obs_t model(input int g, input bit in_rst, input int e,
                                 input bit cap_v, input int cap_p,
                                 input logic [23:0] cap_rgb);
    obs_t o;
    int ht, vt, d, p, ch, cv;
    bit act;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (in_rst) return o;
    ht = C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
    vt = C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g];
    d  = C_DIV[g];
    p  = e / d;
    o.x    = 10'(p % ht);
    o.y    = 10'((p / ht) % vt);
    o.tick = ((e % d) == d - 1);
    o.fs   = o.tick && ((p % ht) == 0) && (((p / ht) % vt) == 0);
    if (cap_v) begin
      ch  = cap_p % ht;
      cv  = (cap_p / ht) % vt;
      act = (ch < C_HA[g]) && (cv < C_VA[g]);
      o.blank = act;
      o.hs = !((ch >= C_HA[g] + C_HF[g]) && (ch < C_HA[g] + C_HF[g] + C_HS[g]));
      o.vs = !((cv >= C_VA[g] + C_VF[g]) && (cv < C_VA[g] + C_VF[g] + C_VS[g]));
      if (act) {o.r, o.g, o.b} = cap_rgb;
    end
    return o;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    logic       rst_n;
    logic [9:0] x, y;
    logic [7:0] red, green, blue;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       hsync, vsync, vga_blank_n, pix_tick, frame_start;

    obs_t        sb[$];
    bit          drv_done;
    int          e;
    bit          in_rst;
    bit          cap_v;
    bit          arm;
    int          cap_p;
    logic [23:0] cap_rgb;
    logic [23:0] cur_rgb;

    localparam int HT = C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
    localparam int VT = C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g];
    localparam int D  = C_DIV[g];

    vga_timing_gen #(
      .H_ACTIVE(C_HA[g]), .H_FP(C_HF[g]), .H_SYNC(C_HS[g]), .H_BP(C_HB[g]),
      .V_ACTIVE(C_VA[g]), .V_FP(C_VF[g]), .V_SYNC(C_VS[g]), .V_BP(C_VB[g]),
      .CLK_DIV(C_DIV[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .red(red), .green(green), .blue(blue),
      .hsync(hsync), .vsync(vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_blank_n(vga_blank_n), .pix_tick(pix_tick), .frame_start(frame_start)
    );

    task automatic chk(input string name, input int got, input int exp_v);
      checks++;
      if (got != exp_v) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL inst%0d %s got=%0d expected=%0d t=%0t", g, name, got, exp_v, $time);
        end
      end
    endtask

    // One clock of stimulus: advance the model, maybe toggle reset, drive RGB.
    task automatic step(input bit release_rst, input bit align);
      int p;
      @(posedge clk);
      if (!in_rst) begin
        e++;
        if ((e % D) == 0) begin
          cap_v   = 1'b1;
          cap_p   = e / D - 1;
          cap_rgb = cur_rgb;
        end
      end
      #2;
      if (arm && !in_rst && e == C_TRIG[g]) begin
        arm    = 1'b0;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        e      = 0;
        cap_v  = 1'b0;
      end
      if (release_rst) begin
        rst_n  = 1'b1;
        in_rst = 1'b0;
        e      = 0;
      end
      if (align && !in_rst) begin
        p = e / D;
        cur_rgb = {8'(p % HT), 8'((p / HT) % VT), 8'hA5};
      end else begin
        cur_rgb = 24'($urandom());
      end
      {red, green, blue} = cur_rgb;
      sb.push_back(model(g, in_rst, e, cap_v, cap_p, cap_rgb));
    endtask

    // Driver: reset, aligned pixel source until mid-frame reset, then random RGB.
    initial begin
      int guard;
      drv_done = 1'b0;
      rst_n    = 1'b1;
      in_rst   = 1'b1;
      e        = 0;
      cap_v    = 1'b0;
      cap_p    = 0;
      cap_rgb  = '0;
      cur_rgb  = '0;
      arm      = 1'b1;
      {red, green, blue} = 24'd0;
      #2 rst_n = 1'b0;
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      guard = 0;
      while (arm && guard < 20000) begin
        step(1'b0, 1'b1);
        guard++;
      end
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (C_RUN2[g]) step(1'b0, 1'b0);
      drv_done = 1'b1;
    end

    // Monitor: compare every sample with the scoreboard and measure intervals.
    initial begin
      obs_t exp_o, got;
      int hs_run, vs_run, bl_run, tk_cnt, ln_cnt, fr_cnt;
      bit tk_seen, ln_seen, fr_seen, prev_hs;
      hs_run = -1; vs_run = -1; bl_run = -1;
      tk_cnt = 0; ln_cnt = 0; fr_cnt = 0;
      tk_seen = 0; ln_seen = 0; fr_seen = 0; prev_hs = 1'b1;
      done_f[g] = 1'b0;
      while (!(drv_done && sb.size() == 0)) begin
        @(negedge clk);
        if (sb.size() == 0) continue;
        exp_o = sb.pop_front();
        got = {x, y, hsync, vsync, vga_blank_n, pix_tick, frame_start, vga_r, vga_g, vga_b};
        checks++;
        if (got !== exp_o) begin
          failures++;
          if (fail_prints < 20) begin
            fail_prints++;
            $display("FAIL inst%0d sample t=%0t got x=%0d y=%0d hs=%b vs=%b bl=%b tk=%b fs=%b rgb=%h expected x=%0d y=%0d hs=%b vs=%b bl=%b tk=%b fs=%b rgb=%h",
                     g, $time, got.x, got.y, got.hs, got.vs, got.blank, got.tick, got.fs,
                     {got.r, got.g, got.b}, exp_o.x, exp_o.y, exp_o.hs, exp_o.vs,
                     exp_o.blank, exp_o.tick, exp_o.fs, {exp_o.r, exp_o.g, exp_o.b});
          end
        end
        if (!rst_n) begin
          hs_run = -1; vs_run = -1; bl_run = -1;
          tk_seen = 0; ln_seen = 0; fr_seen = 0; prev_hs = 1'b1;
        end else begin
          if (!hsync) begin
            if (hs_run >= 0) hs_run++;
          end else begin
            if (hs_run > 0) chk("hsync_low_clks", hs_run, C_HS[g] * D);
            hs_run = 0;
          end
          if (!vsync) begin
            if (vs_run >= 0) vs_run++;
          end else begin
            if (vs_run > 0) chk("vsync_low_clks", vs_run, C_VS[g] * HT * D);
            vs_run = 0;
          end
          if (vga_blank_n) begin
            if (bl_run >= 0) bl_run++;
          end else begin
            if (bl_run > 0) chk("blank_n_high_clks", bl_run, C_HA[g] * D);
            bl_run = 0;
          end
          tk_cnt++;
          if (pix_tick) begin
            if (tk_seen) chk("tick_period", tk_cnt, D);
            tk_seen = 1'b1;
            tk_cnt  = 0;
          end
          ln_cnt++;
          if (prev_hs && !hsync) begin
            if (ln_seen) chk("line_clks", ln_cnt, HT * D);
            ln_seen = 1'b1;
            ln_cnt  = 0;
          end
          prev_hs = hsync;
          fr_cnt++;
          if (frame_start) begin
            if (fr_seen) chk("frame_clks", fr_cnt, HT * VT * D);
            fr_seen = 1'b1;
            fr_cnt  = 0;
          end
        end
      end
      done_f[g] = 1'b1;
    end
  end

  // Completion watchdog and summary.
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 90000 && !all_done; t++) begin
      @(posedge clk);
      all_done = done_f[0] && done_f[1] && done_f[2];
    end
    checks++;
    if (!all_done) begin
      failures++;
      $display("FAIL watchdog got done=%b%b%b expected done=111", done_f[0], done_f[1], done_f[2]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
